// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank for the ADC glue logic: ID/CONTROL/IRQ_MASK/SYNC plus
// per-channel FRAME/OVF/ERR monitors, W1C sticky errors, maskable irq and timed soft reset.
module axi_lite_regbank #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          N_CH       = 4,
  parameter logic [31:0] ID_VALUE   = 32'hd5170007,
  parameter int          RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  input  logic [32*N_CH-1:0]    frame_counter,
  input  logic [32*N_CH-1:0]    overflow_counter,
  input  logic [32*N_CH-1:0]    err_conds,
  input  logic [31:0]           sync_reg,
  output logic [31:0]           control,
  output logic                  pl_resetn,
  output logic                  pl_enable,
  output logic                  irq
);
  localparam int CW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  logic                  rst_done, aw_full, w_full, bvalid, rvalid, irq_r;
  logic [ADDR_WIDTH-3:0] aw_word;
  logic [31:0]           w_data, wmask, rdata, ctrl, ctrl_next;
  logic [3:0]            w_strb;
  logic [1:0]            bresp, rresp;
  logic [N_CH-1:0]       irq_mask, wr_err;
  logic [31:0]           err [N_CH];
  logic [31:0]           err_next [N_CH];
  logic [CW-1:0]         rst_cnt, cnt_next;
  logic [31:0]           wr_word, rd_word, rd_value;
  logic                  wr_ctrl, wr_mask, irq_next;
  resp_t                 wr_resp, rd_resp;
  logic                  aw_hs, w_hs, ar_hs, do_write;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = rst_done && !aw_full && !bvalid;
  assign S_AXI_WREADY  = rst_done && !w_full && !bvalid;
  assign S_AXI_ARREADY = rst_done && !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign control       = ctrl;
  assign pl_resetn     = resetn && !ctrl[1];
  assign pl_enable     = pl_resetn && ctrl[0];
  assign irq           = irq_r;

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign do_write = aw_full && w_full;
  assign wmask    = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign wr_word  = 32'(aw_word);
  assign rd_word  = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);

  // Word index 4+4c..7+4c holds channel c: FRAME, OVF, ERR, reserved.
  always_comb begin
    wr_ctrl = 1'b0;
    wr_mask = 1'b0;
    wr_err  = '0;
    wr_resp = RESP_DECERR;
    if (wr_word == 32'd1) begin
      wr_ctrl = 1'b1;
      wr_resp = RESP_OKAY;
    end else if (wr_word == 32'd2) begin
      wr_mask = 1'b1;
      wr_resp = RESP_OKAY;
    end else if (wr_word < 32'd4) begin
      wr_resp = RESP_SLVERR;
    end
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (wr_word == 4 + 4*c + 2) begin
        wr_err[c] = 1'b1;
        wr_resp   = RESP_OKAY;
      end else if (wr_word >= 4 + 4*c && wr_word <= 4 + 4*c + 3) begin
        wr_resp = RESP_SLVERR;
      end
    end
  end

  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_DECERR;
    if (rd_word == 32'd0) begin
      rd_value = ID_VALUE;
      rd_resp  = RESP_OKAY;
    end else if (rd_word == 32'd1) begin
      rd_value = ctrl;
      rd_resp  = RESP_OKAY;
    end else if (rd_word == 32'd2) begin
      rd_value = 32'(irq_mask);
      rd_resp  = RESP_OKAY;
    end else if (rd_word == 32'd3) begin
      rd_value = sync_reg;
      rd_resp  = RESP_OKAY;
    end
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (rd_word == 4 + 4*c) begin
        rd_value = frame_counter[32*c +: 32];
        rd_resp  = RESP_OKAY;
      end else if (rd_word == 5 + 4*c) begin
        rd_value = overflow_counter[32*c +: 32];
        rd_resp  = RESP_OKAY;
      end else if (rd_word == 6 + 4*c) begin
        rd_value = err[c];
        rd_resp  = RESP_OKAY;
      end else if (rd_word == 7 + 4*c) begin
        rd_value = '0;
        rd_resp  = RESP_OKAY;
      end
    end
  end

  // Hardware self-clear of bit1 is applied first so a coincident rewrite re-arms it.
  always_comb begin
    ctrl_next = ctrl;
    cnt_next  = (rst_cnt != '0) ? rst_cnt - 1'b1 : '0;
    if (rst_cnt == CW'(1)) ctrl_next[1] = 1'b0;
    if (do_write && wr_ctrl) begin
      ctrl_next = (ctrl_next & ~wmask) | (w_data & wmask);
      if (wmask[1] && w_data[1]) cnt_next = CW'(RST_HOLD);
      else if (!ctrl_next[1])    cnt_next = '0;
    end
    irq_next = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      err_next[c] = (err[c] & ~((do_write && wr_err[c]) ? (w_data & wmask) : '0))
                    | err_conds[32*c +: 32];
      if (irq_mask[c] && err[c] != '0) irq_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_done <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_word  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      rvalid   <= 1'b0;
      rresp    <= '0;
      rdata    <= '0;
      ctrl     <= '0;
      irq_mask <= '0;
      err      <= '{default: '0};
      rst_cnt  <= '0;
      irq_r    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_word <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (do_write) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_resp;
        if (wr_mask)
          irq_mask <= (irq_mask & ~wmask[N_CH-1:0]) | (w_data[N_CH-1:0] & wmask[N_CH-1:0]);
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_value;
        rresp  <= rd_resp;
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
      ctrl    <= ctrl_next;
      rst_cnt <= cnt_next;
      err     <= err_next;
      irq_r   <= irq_next;
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed scenarios plus randomized AXI-Lite
// traffic compared against an address-map reference model.
module tb_axi_lite_regbank;
  localparam int          AW   = 8;
  localparam int          NC   = 4;
  localparam int          HOLD = 4;
  localparam logic [31:0] ID   = 32'hd5170007;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]   S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic [32*NC-1:0] frame_counter, overflow_counter, err_conds;
  logic [31:0]   sync_reg, control;
  logic          pl_resetn, pl_enable, irq;

  axi_lite_regbank #(.ADDR_WIDTH(AW), .N_CH(NC), .ID_VALUE(ID), .RST_HOLD(HOLD)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .frame_counter(frame_counter), .overflow_counter(overflow_counter), .err_conds(err_conds),
    .sync_reg(sync_reg), .control(control), .pl_resetn(pl_resetn), .pl_enable(pl_enable),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of the architectural registers.
  logic [31:0]   m_ctrl;
  logic [NC-1:0] m_mask;
  logic [31:0]   m_err [NC];

  task automatic model_reset();
    m_ctrl = '0;
    m_mask = '0;
    for (int c = 0; c < NC; c++) m_err[c] = '0;
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hff : 8'h00;
    return m;
  endfunction

  task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
    int off, ch, sub;
    off = int'(a) / 4 * 4;
    d = '0;
    r = 2'b00;
    if (off == 'h00)      d = ID;
    else if (off == 'h04) d = m_ctrl;
    else if (off == 'h08) d = 32'(m_mask);
    else if (off == 'h0C) d = sync_reg;
    else begin
      ch  = (off - 'h10) / 16;
      sub = (off - 'h10) % 16;
      if (ch >= NC) r = 2'b11;
      else if (sub == 0) d = frame_counter[32*ch +: 32];
      else if (sub == 4) d = overflow_counter[32*ch +: 32];
      else if (sub == 8) d = m_err[ch];
    end
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    int off, ch, sub;
    logic [31:0] bm;
    bm  = strb_mask(s);
    off = int'(a) / 4 * 4;
    r   = 2'b10;
    if (off == 'h04) begin
      m_ctrl = (m_ctrl & ~bm) | (d & bm);
      r = 2'b00;
    end else if (off == 'h08) begin
      m_mask = NC'(((32'(m_mask) & ~bm) | (d & bm)));
      r = 2'b00;
    end else if (off >= 'h10) begin
      ch  = (off - 'h10) / 16;
      sub = (off - 'h10) % 16;
      if (ch >= NC) r = 2'b11;
      else if (sub == 8) begin
        m_err[ch] = m_err[ch] & ~(d & bm);
        r = 2'b00;
      end
    end
  endtask

  function automatic logic model_irq();
    logic x = 1'b0;
    for (int c = 0; c < NC; c++) if (m_mask[c] && m_err[c] != 0) x = 1'b1;
    return x;
  endfunction

  // Cycle-indexed observation of edges that the timing checks refer to.
  int  cyc = 0;
  int  bv_rise = -1;
  int  irq_fall = -1;
  int  en_bad = 0;
  int  low_q[$];
  logic bv_q = 1'b0, irq_q = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (S_AXI_BVALID && !bv_q) bv_rise = cyc;
    if (!irq && irq_q) irq_fall = cyc;
    bv_q  = S_AXI_BVALID;
    irq_q = irq;
    if (resetn && !pl_resetn) begin
      low_q.push_back(cyc);
      if (pl_enable) en_bad++;
    end
  end

  task automatic send_aw(input logic [AW-1:0] a, input int dly);
    logic hs = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_AWADDR = a;
    S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = S_AXI_AWREADY;
      @(posedge clk); #1;
    end
    S_AXI_AWVALID = 1'b0;
    check("aw_handshake", 32'(hs), 32'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    logic hs = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_WDATA = d;
    S_AXI_WSTRB = s;
    S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = S_AXI_WREADY;
      @(posedge clk); #1;
    end
    S_AXI_WVALID = 1'b0;
    check("w_handshake", 32'(hs), 32'd1);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd, output logic [1:0] resp);
    logic ok = 1'b0;
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = S_AXI_BVALID;
    end
    check("bvalid_seen", 32'(ok), 32'd1);
    repeat (bd) begin
      @(negedge clk);
      check("bvalid_held", 32'(S_AXI_BVALID), 32'd1);
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int rd_dly,
                          output logic [31:0] d, output logic [1:0] resp);
    logic hs = 1'b0, ok = 1'b0;
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = S_AXI_ARREADY;
      @(posedge clk); #1;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_handshake", 32'(hs), 32'd1);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = S_AXI_RVALID;
    end
    check("rvalid_seen", 32'(ok), 32'd1);
    d = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    repeat (rd_dly) begin
      @(negedge clk);
      check("rdata_stable", S_AXI_RDATA, d);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awd, input int wd, input int bd);
    logic [1:0] r, er;
    axi_write(a, d, s, awd, wd, bd, r);
    model_write(a, d, s, er);
    check({tag, "_bresp"}, 32'(r), 32'(er));
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input int rd_dly);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    axi_read(a, rd_dly, d, r);
    model_read(a, ed, er);
    check({tag, "_rdata"}, d, ed);
    check({tag, "_rresp"}, 32'(r), 32'(er));
  endtask

  task automatic pulse_err(input logic [32*NC-1:0] v);
    err_conds = v;
    @(posedge clk); #1;
    err_conds = '0;
    for (int c = 0; c < NC; c++) m_err[c] |= v[32*c +: 32];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r1, r2, ok;
    logic [31:0] d, a32;
    logic [32*NC-1:0] ev;

    resetn = 1'b0;
    {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY} = '0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    err_conds = '0;
    for (int c = 0; c < NC; c++) begin
      frame_counter[32*c +: 32]    = $urandom;
      overflow_counter[32*c +: 32] = $urandom;
    end
    sync_reg = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state and readiness one cycle after release.
    @(negedge clk);
    check("awready_in_release_cycle", 32'(S_AXI_AWREADY), 32'd0);
    @(negedge clk);
    check("awready_after_reset", 32'(S_AXI_AWREADY), 32'd1);
    check("wready_after_reset", 32'(S_AXI_WREADY), 32'd1);
    check("arready_after_reset", 32'(S_AXI_ARREADY), 32'd1);
    check("irq_reset", 32'(irq), 32'd0);
    check("pl_enable_reset", 32'(pl_enable), 32'd0);
    check("pl_resetn_reset", 32'(pl_resetn), 32'd1);
    check("control_reset", control, 32'd0);
    @(posedge clk); #1;
    do_read("id", 8'h00, 0);
    do_read("mask_reset", 8'h08, 1);

    // W leads AW by 3 cycles, BREADY held off 2 cycles, then byte-lane gating.
    do_write("ctrl_en", 8'h04, 32'h5, 4'b0001, 3, 0, 2);
    @(negedge clk);
    check("bvalid_cleared", 32'(S_AXI_BVALID), 32'd0);
    check("control_en", control, 32'h5);
    check("pl_enable_on", 32'(pl_enable), 32'd1);
    @(posedge clk); #1;
    do_write("ctrl_lane1", 8'h04, 32'hffffffff, 4'b0010, 0, 1, 0);
    check("control_lane1", control, 32'h0000ff05);

    // Soft reset holds pl_resetn low for exactly HOLD cycles.
    n0 = low_q.size();
    do_write("srst", 8'h04, 32'h3, 4'b0001, 0, 0, 0);
    r1 = bv_rise;
    repeat (12) @(posedge clk);
    #1;
    m_ctrl[1] = 1'b0;
    check("srst_low_count", 32'(low_q.size() - n0), 32'(HOLD));
    check("srst_low_first", 32'(low_q[n0]), 32'(r1));
    check("srst_low_last", 32'(low_q[low_q.size()-1]), 32'(r1 + HOLD - 1));
    do_read("ctrl_after_srst", 8'h04, 0);
    check("pl_enable_after_srst", 32'(pl_enable), 32'd1);

    n0 = low_q.size();
    do_write("srst_a", 8'h04, 32'h3, 4'b0001, 0, 0, 0);
    r1 = bv_rise;
    do_write("srst_b", 8'h04, 32'h3, 4'b0001, 0, 0, 0);
    r2 = bv_rise;
    check("srst_rewrite_in_hold", 32'(r2 - r1 < HOLD), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    m_ctrl[1] = 1'b0;
    check("srst_ext_low_count", 32'(low_q.size() - n0), 32'(r2 + HOLD - r1));
    check("srst_ext_low_last", 32'(low_q[low_q.size()-1]), 32'(r2 + HOLD - 1));
    check("pl_enable_during_srst", 32'(en_bad), 32'd0);
    check("control_after_ext", control, m_ctrl);

    // ERR[2] sticky set, masked irq, W1C clear and set-wins-over-clear.
    ev = '0; ev[64 +: 32] = 32'h10;
    pulse_err(ev);
    do_read("err2_set", 8'h38, 0);
    do_write("mask_ch2", 8'h08, 32'h4, 4'b1111, 0, 0, 0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    @(posedge clk); #1;
    do_write("err2_clr", 8'h38, 32'h10, 4'b1111, 1, 0, 1);
    check("irq_fall_delay", 32'(irq_fall), 32'(bv_rise + 1));
    check("irq_cleared", 32'(irq), 32'd0);
    do_read("err2_clr", 8'h38, 0);

    err_conds = ev;
    m_err[2] |= 32'h10;
    @(posedge clk); #1;
    fork
      do_write("err2_clr_set", 8'h38, 32'h10, 4'b1111, 0, 0, 1);
      begin
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
          @(negedge clk); if (S_AXI_BVALID) ok = 1;
        end
        err_conds = '0;
      end
    join
    m_err[2] |= 32'h10;
    do_read("err2_set_wins", 8'h38, 0);

    // RO targets and decode errors.
    do_write("wr_id", 8'h00, 32'h12345678, 4'b1111, 0, 0, 0);
    do_write("wr_frame0", 8'h10, 32'h12345678, 4'b1111, 0, 0, 0);
    do_read("id_unchanged", 8'h00, 0);
    do_read("frame0_unchanged", 8'h10, 0);
    do_write("wr_decerr", 8'h60, 32'hffffffff, 4'b1111, 0, 0, 0);
    do_read("rd_decerr", 8'h60, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 3) == 0) a32 = $urandom_range(0, 255);
      else a32 = $urandom_range(0, 'h10 + 16*NC - 1);
      if ($urandom_range(0, 4) == 0) begin
        ev = '0;
        for (int c = 0; c < NC; c++) ev[32*c +: 32] = $urandom & $urandom & $urandom;
        pulse_err(ev);
      end
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        if (a32[7:2] == 6'd1) d[1] = 1'b0;
        do_write("rand_wr", AW'(a32), d, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read("rand_rd", AW'(a32), $urandom_range(0, 3));
      end
      check("rand_irq", 32'(irq), 32'(model_irq()));
      check("rand_control", control, m_ctrl);
      check("rand_pl_enable", 32'(pl_enable), 32'(m_ctrl[0]));
    end

    // Reset with an address latched and a read response pending.
    do_write("pre_rst_mask", 8'h08, 32'hf, 4'b0001, 0, 0, 0);
    do_write("pre_rst_ctrl", 8'h04, 32'h5, 4'b0001, 0, 0, 0);
    send_aw(8'h04, 0);
    S_AXI_ARADDR = 8'h00;
    S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("rvalid_pending", 32'(S_AXI_RVALID), 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_control", control, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge clk); #1;
    do_read("rst_mask", 8'h08, 0);
    do_read("rst_err2", 8'h38, 0);
    do_write("post_rst", 8'h04, 32'h1, 4'b0001, 0, 2, 0);
    check("post_rst_control", control, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
